// File: rtl/op_sel_pkg.sv
// ============================================================================
// Module : op_sel_pkg
// Brief  : Shared FSM state encoding, sizing constants and ss step helper
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package op_sel_pkg;

  typedef enum logic [1:0] {
    S_LOAD_A = 2'd0,
    S_LOAD_B = 2'd1,
    S_SEL_OP = 2'd2,
    S_SHOW   = 2'd3
  } state_t;

  localparam int NUM_OPS_DEF = 11;
  localparam int SS_W        = 4;

  // Advance the op select, wrapping at the last legal op so ss never leaves 0..num_ops-1.
  function automatic logic [SS_W-1:0] ss_advance(input logic [SS_W-1:0] cur, input int num_ops);
    return (cur == SS_W'(num_ops - 1)) ? '0 : cur + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_conditioner.sv
// ============================================================================
// Module : btn_conditioner
// Brief  : 2-flop sync, optional debounce (OP_SEL_DEBOUNCE_EN), rising-edge pulse
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_conditioner #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic level;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= level;
    end
  end

`ifdef OP_SEL_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deb_q, deb_d;

  // Counter runs only while the synced level disagrees with the accepted level;
  // any return to agreement restarts the stability window.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign level = deb_q;
`else
  logic unused_deb_cfg;
  assign unused_deb_cfg = (DEB_CYCLES == 0);
  assign level          = sync2_q;
`endif

  assign pulse = level & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/op_select_ctrl.sv
// ============================================================================
// Module : op_select_ctrl
// Brief  : Operand capture and op-select FSM driving the result mux; optional
//          button debounce enabled by defining OP_SEL_DEBOUNCE_EN
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module op_select_ctrl
  import op_sel_pkg::*;
#(
  parameter int N          = 4,
  parameter int NUM_OPS    = NUM_OPS_DEF,
  parameter int DEB_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    sw,
  input  logic            btn_next,
  input  logic            btn_back,
  output logic [N-1:0]    a_out,
  output logic [N-1:0]    b_out,
  output logic [SS_W-1:0] ss,
  output logic [1:0]      state_out,
  output logic            valid
);

  logic next_p;
  logic back_p;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_next (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_next),
    .pulse   (next_p)
  );

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_cond_back (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_back),
    .pulse   (back_p)
  );

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [SS_W-1:0] ss_q, ss_d;
  logic            valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ss_d    = ss_q;
    // Simultaneous pulses are ambiguous operator input and are dropped.
    if (next_p && !back_p) begin
      case (state_q)
        S_LOAD_A: begin a_d = sw; state_d = S_LOAD_B; end
        S_LOAD_B: begin b_d = sw; state_d = S_SEL_OP; end
        S_SEL_OP: ss_d = ss_advance(ss_q, NUM_OPS);
        S_SHOW:   state_d = S_SEL_OP;
        default:  state_d = S_LOAD_A;
      endcase
    end else if (back_p && !next_p) begin
      case (state_q)
        S_LOAD_A: state_d = S_LOAD_A;
        S_LOAD_B: state_d = S_LOAD_A;
        S_SEL_OP: state_d = S_SHOW;
        S_SHOW: begin
          state_d = S_LOAD_A;
          a_d     = '0;
          b_d     = '0;
          ss_d    = '0;
        end
        default:  state_d = S_LOAD_A;
      endcase
    end
    valid_d = (state_d == S_SHOW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      ss_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ss_q    <= ss_d;
      valid_q <= valid_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign ss        = ss_q;
  assign state_out = state_q;
  assign valid     = valid_q;

endmodule

`default_nettype wire
